// File: rtl/tt_pkg.sv
// Shared types and constants for the 3-input truth-table sweep controller.
package tt_pkg;

    localparam int TT_ROWS = 8;
    localparam int TT_IN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } tt_state_e;

    // Gate naming reads rows 000..111 from MSB to LSB, so row 0 lands in bit 7.
    function automatic logic [TT_IN_W-1:0] tt_bit(input logic [TT_IN_W-1:0] row);
        return TT_IN_W'(TT_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Up-counting settle timer with clear-on-load and terminal-count flag.
module tt_settle_timer #(
    parameter int CNT_W = 8,
    parameter int TERM  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == CNT_W'(TERM - 1));

    // Count register: load clears it, enable advances it by one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks a 3-input gate through all eight rows,
// captures its output per row and compares the assembled code to EXPECTED.
//
//   state  | meaning
//   IDLE   | waiting for start, outputs held
//   SETTLE | inputs applied, waiting SETTLE cycles; pre-sample taken on last one
//   SAMPLE | capture gate output into code, advance row or finish
//   DONE   | one-cycle completion pulse, match valid
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int         SETTLE   = 4,
    parameter logic [7:0] EXPECTED = 8'h2B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [TT_IN_W-1:0] dut_in,
    input  logic               dut_out,
    output logic               busy,
    output logic               done,
    output logic [7:0]         code,
    output logic               match,
    output logic               unstable
);

    tt_state_e          r_state;
    tt_state_e          w_state_next;
    logic [TT_IN_W-1:0] r_row;
    logic [7:0]         r_code;
    logic [7:0]         w_code_next;
    logic               r_match;
    logic               r_unstable;
    logic               r_pre;
    logic               w_accept;
    logic               w_last_row;
    logic               w_tmr_load;
    logic               w_tmr_en;
    logic               w_tmr_tc;

    tt_settle_timer #(
        .CNT_W (8),
        .TERM  (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .i_en   (w_tmr_en),
        .o_tc   (w_tmr_tc)
    );

    assign w_last_row = (r_row == TT_IN_W'(TT_ROWS - 1));

    // Next-state decode plus status outputs and timer controls.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept     = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_tmr_load   = 1'b1;
                w_state_next = w_last_row ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Code with the current row's capture merged in; used for match on the last row.
    always_comb begin
        w_code_next                = r_code;
        w_code_next[tt_bit(r_row)] = dut_out;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row pointer (also the gate input vector), capture and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_code     <= '0;
            r_match    <= 1'b0;
            r_unstable <= 1'b0;
            r_pre      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row      <= '0;
                r_code     <= '0;
                r_match    <= 1'b0;
                r_unstable <= 1'b0;
            end
            if (r_state == ST_SETTLE && w_tmr_tc) begin
                r_pre <= dut_out;
            end
            if (r_state == ST_SAMPLE) begin
                r_code <= w_code_next;
                if (dut_out != r_pre) begin
                    r_unstable <= 1'b1;
                end
                if (w_last_row) begin
                    // Match is registered here so it is already valid in DONE.
                    r_match <= (w_code_next == EXPECTED);
                end else begin
                    r_row <= r_row + TT_IN_W'(1);
                end
            end
        end
    end

    assign dut_in   = r_row;
    assign code     = r_code;
    assign match    = r_match;
    assign unstable = r_unstable;

endmodule
